// File: rtl/ip_spad_pkg.sv
// Shared configuration for the input-activation scratchpad: word/depth constants
// and the controller request bundle driven by the datapath controller.
package ip_spad_pkg;

  localparam int unsigned IP_DW    = 16;
  localparam int unsigned IP_DEPTH = 16;
  localparam int unsigned IP_AW    = $clog2(IP_DEPTH);

  // Read request plus pop/clear command; addr is an offset from the current head.
  typedef struct packed {
    logic             rd;
    logic [IP_AW-1:0] addr;
    logic             pop;
    logic [IP_AW:0]   pop_n;
    logic             clear;
  } ipad_addr_t;

endpackage

// File: rtl/spad_rf.sv
// Scratchpad register file: one write port, one registered read port.
// Shared by the input, weight and psum pads.
module spad_rf #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds its value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ip_spad.sv
// Input-activation scratchpad: circular buffer filled by the array feeder, read at
// head-relative offsets by the MAC datapath, and retired by controller pops.
module ip_spad
  import ip_spad_pkg::*;
#(
  parameter int unsigned DW    = IP_DW,
  parameter int unsigned DEPTH = IP_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_Input_rdy,
  output logic          o_Input_ack,
  input  logic [DW-1:0] i_Input_data,
  input  ipad_addr_t    i_IPctl,
  output logic [DW-1:0] o_ip_data,
  output logic          o_ip_valid,
  output logic          o_ip_miss,
  output logic [AW:0]   o_count,
  output logic          o_pop_err
);

  localparam logic [AW:0] Full = DEPTH[AW:0];

  logic [AW-1:0] head_q, head_d, tail_q, tail_d, raddr;
  logic [AW:0]   count_q, count_d, pop_amt;
  logic          pop_err_q, pop_err_d, valid_q;
  logic          wr, hit, over;

  always_comb begin
    o_Input_ack = (count_q != Full) && !i_IPctl.clear;
    wr          = i_Input_rdy && o_Input_ack;
    hit         = i_IPctl.rd && ({1'b0, i_IPctl.addr} < count_q) && !i_IPctl.clear;
    o_ip_miss   = i_IPctl.rd && ({1'b0, i_IPctl.addr} >= count_q);
    over        = i_IPctl.pop && (i_IPctl.pop_n > count_q);
    raddr       = head_q + i_IPctl.addr;

    // Pops are bounded by the pre-update occupancy, so a same-cycle write survives.
    pop_amt = '0;
    if (i_IPctl.pop) begin
      pop_amt = over ? count_q : i_IPctl.pop_n;
    end

    head_d    = head_q + pop_amt[AW-1:0];
    tail_d    = tail_q + {{(AW-1){1'b0}}, wr};
    count_d   = count_q + {{AW{1'b0}}, wr} - pop_amt;
    pop_err_d = pop_err_q | over;

    if (i_IPctl.clear) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      pop_err_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pop_err_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      pop_err_q <= pop_err_d;
      valid_q   <= hit;
    end
  end

  spad_rf #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rf (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .we    (wr),
    .waddr (tail_q),
    .wdata (i_Input_data),
    .re    (hit),
    .raddr (raddr),
    .rdata (o_ip_data)
  );

  assign o_ip_valid = valid_q;
  assign o_count    = count_q;
  assign o_pop_err  = pop_err_q;

endmodule
